// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - read/write/busywait memory handshake bundle
// master drives the strobes/address/data, slave answers with readdata and busywait.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a single memory port
// D has priority; a streak counter forces an I grant after FAIR_LIMIT D grants while I waits.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave  i_bus,
  mem_port_arbiter_if.slave  d_bus,
  mem_port_arbiter_if.master m_bus
);
  localparam int            SW         = $clog2(FAIR_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_LIMIT);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SERVE_I = 3'd1;
  localparam logic [2:0] SERVE_D = 3'd2;
  localparam logic [2:0] DONE_I  = 3'd3;
  localparam logic [2:0] DONE_D  = 3'd4;

  logic [2:0]        state;
  logic [SW-1:0]     streak;
  logic              m_read_q;
  logic              m_write_q;
  logic [ADDR_W-1:0] m_address_q;
  logic [DATA_W-1:0] m_writedata_q;
  logic [DATA_W-1:0] i_readdata_q;
  logic [DATA_W-1:0] d_readdata_q;
  logic              d_req;
  logic              force_i;
  logic              grant_d;
  logic              grant_i;

  assign d_req   = d_bus.read | d_bus.write;
  assign force_i = i_bus.read && (streak == STREAK_MAX);
  assign grant_d = (state == IDLE) && d_req && !force_i;
  assign grant_i = (state == IDLE) && i_bus.read && !(d_req && !force_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      streak        <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      i_readdata_q  <= '0;
      d_readdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state         <= SERVE_D;
            m_address_q   <= d_bus.address;
            m_writedata_q <= d_bus.writedata;
            // read+write together is treated as a plain write
            m_write_q     <= d_bus.write;
            m_read_q      <= d_bus.read & ~d_bus.write;
            if (i_bus.read)
              streak <= (streak == STREAK_MAX) ? streak : streak + SW'(1);
            else
              streak <= '0;
          end else if (grant_i) begin
            state       <= SERVE_I;
            m_address_q <= i_bus.address;
            m_read_q    <= 1'b1;
            streak      <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (!m_bus.busywait) begin
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            if (m_read_q) begin
              if (state == SERVE_I) i_readdata_q <= m_bus.readdata;
              else                  d_readdata_q <= m_bus.readdata;
            end
            state <= (state == SERVE_I) ? DONE_I : DONE_D;
          end
        end
        DONE_I, DONE_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  // Requesters see busywait drop only for the single DONE cycle of their own access.
  assign i_bus.busywait  = i_bus.read && (state != DONE_I);
  assign d_bus.busywait  = d_req && (state != DONE_D);
  assign i_bus.readdata  = i_readdata_q;
  assign d_bus.readdata  = d_readdata_q;

  assign m_bus.read      = m_read_q;
  assign m_bus.write     = m_write_q;
  assign m_bus.address   = m_address_q;
  assign m_bus.writedata = m_writedata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a transaction-level arbiter model
// A bench memory with programmable wait states sits on the M side.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int FAIR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i_bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR_LIMIT(FAIR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .m_bus (m_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // bench memory: busywait high for mem_wait edges of each access
  logic [31:0] mem_arr [0:255];
  int          mem_wait = 0;
  int          wcnt;
  logic        m_strobe;

  assign m_strobe       = m_bus.read | m_bus.write;
  assign m_bus.busywait = m_strobe && (wcnt < mem_wait);
  assign m_bus.readdata = mem_arr[m_bus.address[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (m_strobe && wcnt < mem_wait) wcnt <= wcnt + 1;
    else if (m_strobe) begin
      if (m_bus.write) mem_arr[m_bus.address[9:2]] <= m_bus.writedata;
    end else wcnt <= 0;
  end

  // model: one outstanding access; t counts edges since grant, W is its wait count
  logic        mdl_busy, mdl_rd, mdl_is_d;
  int          mdl_t, mdl_w, mdl_streak;
  logic [31:0] exp_addr, exp_wdata, exp_i_rd, exp_d_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0; mdl_rd <= 1'b0; mdl_is_d <= 1'b0;
      mdl_t <= 0; mdl_w <= 0; mdl_streak <= 0;
      exp_addr <= '0; exp_wdata <= '0; exp_i_rd <= '0; exp_d_rd <= '0;
    end else if (!mdl_busy) begin
      if ((d_bus.read || d_bus.write) && !(i_bus.read && mdl_streak == FAIR)) begin
        mdl_busy <= 1'b1; mdl_is_d <= 1'b1; mdl_rd <= !d_bus.write;
        mdl_t <= 0; mdl_w <= mem_wait;
        exp_addr <= d_bus.address; exp_wdata <= d_bus.writedata;
        mdl_streak <= i_bus.read ? ((mdl_streak < FAIR) ? mdl_streak + 1 : FAIR) : 0;
      end else if (i_bus.read) begin
        mdl_busy <= 1'b1; mdl_is_d <= 1'b0; mdl_rd <= 1'b1;
        mdl_t <= 0; mdl_w <= mem_wait;
        exp_addr <= i_bus.address; mdl_streak <= 0;
      end
    end else begin
      if (mdl_t == mdl_w && mdl_rd) begin
        if (mdl_is_d) exp_d_rd <= mem_arr[exp_addr[9:2]];
        else          exp_i_rd <= mem_arr[exp_addr[9:2]];
      end
      if (mdl_t == mdl_w + 1) mdl_busy <= 1'b0;
      mdl_t <= mdl_t + 1;
    end
  end

  logic        prev_strobe = 1'b0;
  logic [31:0] grant_q [$];

  always @(negedge clk) begin : cmp
    logic es, ed;
    es = mdl_busy && (mdl_t <= mdl_w);
    ed = mdl_busy && (mdl_t == mdl_w + 1);
    chk_bit("m_read", m_bus.read, es && mdl_rd);
    chk_bit("m_write", m_bus.write, es && !mdl_rd);
    chk("m_address", m_bus.address, exp_addr);
    chk("m_writedata", m_bus.writedata, exp_wdata);
    chk("i_readdata", i_bus.readdata, exp_i_rd);
    chk("d_readdata", d_bus.readdata, exp_d_rd);
    chk_bit("i_busywait", i_bus.busywait, i_bus.read && !(ed && !mdl_is_d));
    chk_bit("d_busywait", d_bus.busywait, (d_bus.read || d_bus.write) && !(ed && mdl_is_d));
    if (m_strobe && !prev_strobe) grant_q.push_back(m_bus.address);
    prev_strobe <= m_strobe;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input bit is_d, input int budget);
    int n = 0;
    while ((is_d ? d_bus.busywait : i_bus.busywait) && n < budget) begin
      step();
      n++;
    end
    chk_bit(is_d ? "d_wait_bound" : "i_wait_bound", is_d ? d_bus.busywait : i_bus.busywait, 1'b0);
  endtask

  initial begin
    int n0, got, n;
    i_bus.read = 0; i_bus.write = 0; i_bus.address = '0; i_bus.writedata = '0;
    d_bus.read = 0; d_bus.write = 0; d_bus.address = '0; d_bus.writedata = '0;
    for (int k = 0; k < 256; k++) mem_arr[k] = 32'h0;
    mem_arr[16] = 32'h0000_0013;
    mem_arr[64] = 32'h1111_0100;
    repeat (3) step();
    chk_bit("rst_m_read", m_bus.read, 1'b0);
    chk("rst_m_address", m_bus.address, 32'h0);
    chk("rst_i_readdata", i_bus.readdata, 32'h0);
    rst_n = 1'b1;
    step();

    // fetch with two wait states
    mem_wait = 2;
    i_bus.address = 32'h40; i_bus.read = 1;
    step();
    chk_bit("t1_m_read", m_bus.read, 1'b1);
    chk("t1_m_address", m_bus.address, 32'h40);
    chk_bit("t1_i_busy", i_bus.busywait, 1'b1);
    wait_done(0, 20);
    chk("t1_i_readdata", i_bus.readdata, 32'h13);
    step(); i_bus.read = 0;

    // simultaneous I read and D write: D first
    i_bus.address = 32'h100; i_bus.read = 1;
    d_bus.address = 32'h200; d_bus.writedata = 32'hDEAD_BEEF; d_bus.write = 1;
    step();
    chk_bit("t2_m_write", m_bus.write, 1'b1);
    chk_bit("t2_m_read", m_bus.read, 1'b0);
    chk("t2_m_address", m_bus.address, 32'h200);
    chk("t2_m_writedata", m_bus.writedata, 32'hDEAD_BEEF);
    chk_bit("t2_i_busy", i_bus.busywait, 1'b1);
    wait_done(1, 20);
    chk_bit("t2_i_busy_done_d", i_bus.busywait, 1'b1);
    step(); d_bus.write = 0;
    step();
    chk_bit("t2_m_read_i", m_bus.read, 1'b1);
    chk("t2_m_address_i", m_bus.address, 32'h100);
    wait_done(0, 20);
    chk("t2_i_readdata", i_bus.readdata, 32'h1111_0100);
    chk("t2_mem_written", mem_arr[128], 32'hDEAD_BEEF);
    step(); i_bus.read = 0;

    // fairness: D held with I waiting
    mem_wait = 1;
    n0 = grant_q.size();
    d_bus.address = 32'h200; d_bus.read = 1;
    i_bus.address = 32'h100; i_bus.read = 1;
    n = 0;
    while (grant_q.size() < n0 + 10 && n < 200) begin
      step();
      n++;
    end
    d_bus.read = 0; i_bus.read = 0;
    got = grant_q.size() - n0;
    chk_bit("t3_grant_count", got >= 10, 1'b1);
    for (int k = 0; k < 10; k++)
      if (n0 + k < grant_q.size())
        chk($sformatf("t3_grant%0d", k), grant_q[n0 + k], (k == 4 || k == 9) ? 32'h100 : 32'h200);
    repeat (4) step();
    chk_bit("t3_idle_read", m_bus.read, 1'b0);

    // reset in the middle of a D write
    mem_wait = 5;
    d_bus.address = 32'h80; d_bus.writedata = 32'h1234_5678; d_bus.write = 1;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    chk_bit("t4_m_write", m_bus.write, 1'b0);
    chk("t4_m_address", m_bus.address, 32'h0);
    chk("t4_m_writedata", m_bus.writedata, 32'h0);
    chk("t4_d_readdata", d_bus.readdata, 32'h0);
    chk("t4_i_readdata", i_bus.readdata, 32'h0);
    step();
    step();
    chk("t4_not_written", mem_arr[32], 32'h0);
    rst_n = 1'b1;
    step();
    chk_bit("t4_regrant", m_bus.write, 1'b1);
    chk("t4_regrant_addr", m_bus.address, 32'h80);
    wait_done(1, 20);
    chk("t4_mem_written", mem_arr[32], 32'h1234_5678);
    step(); d_bus.write = 0;
    step();

    // zero-wait D read latency, request held across DONE
    mem_wait = 0;
    d_bus.address = 32'h40; d_bus.read = 1;
    step();
    chk_bit("t6_e1_busy", d_bus.busywait, 1'b1);
    chk_bit("t6_e1_m_read", m_bus.read, 1'b1);
    step();
    chk_bit("t6_e2_busy", d_bus.busywait, 1'b0);
    chk("t6_d_readdata", d_bus.readdata, 32'h13);
    step();
    chk_bit("t6_e3_m_read", m_bus.read, 1'b0);
    chk_bit("t6_e3_busy", d_bus.busywait, 1'b1);
    step();
    chk_bit("t6_e4_m_read", m_bus.read, 1'b1);
    wait_done(1, 20);
    step(); d_bus.read = 0;

    // read+write together behaves as a write
    mem_wait = 1;
    d_bus.address = 32'h300; d_bus.writedata = 32'hCAFE_F00D;
    d_bus.read = 1; d_bus.write = 1;
    step();
    chk_bit("t5_m_write", m_bus.write, 1'b1);
    chk_bit("t5_m_read", m_bus.read, 1'b0);
    wait_done(1, 20);
    chk("t5_d_readdata", d_bus.readdata, 32'h13);
    chk("t5_mem_written", mem_arr[192], 32'hCAFE_F00D);
    step(); d_bus.read = 0; d_bus.write = 0;

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
